inst_mem_responder: RTL and testbench

- Instruction-memory end of the fetch interface: accepts fetch read requests (address from the Program Counter) and returns 32-bit instruction words with a configurable wait-state count.
- Drives a busy flag so the Fetch phase stalls while a read is outstanding.
- Provides a boot-loader write port used to fill the word array before or between fetches.
- Sits between top_fetch and the instruction storage, replacing the direct BlockRAM hookup.

---
 rtl/inst_mem_responder.sv | 138 +++++++++++++
 tb/tb_inst_mem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder for the fetch interface.
// Returns one word per fetch request after WAIT_CYCLES extra wait states and
// drives inst_busy while a read is outstanding. A boot-loader port fills the
// word array whenever the responder is idle and no fetch is being requested.
module inst_mem_responder #(
    parameter int XLEN        = 32,
    parameter int AWIDTH      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_req,
    input  logic [AWIDTH-1:0] inst_addr,
    output logic [XLEN-1:0]   inst_data,
    output logic              inst_valid,
    output logic              inst_busy,
    output logic              inst_misaligned,
    input  logic              load_we,
    input  logic [AWIDTH-1:0] load_addr,
    input  logic [XLEN-1:0]   load_wdata,
    output logic              load_ready
);

    localparam int IW    = AWIDTH - 2;
    localparam int DEPTH = 1 << IW;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [IW-1:0]     req_idx;
    logic              req_mis;
    logic [XLEN-1:0]   mem [0:DEPTH-1];

    logic [IW-1:0]     addr_idx;
    logic [IW-1:0]     load_idx;
    logic              addr_mis;
    logic              unused_load_lsb;

    assign addr_idx        = inst_addr[AWIDTH-1:2];
    assign load_idx        = load_addr[AWIDTH-1:2];
    assign addr_mis        = |inst_addr[1:0];
    assign unused_load_lsb = &{1'b0, load_addr[1:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus combinational busy/valid/loader-accept outputs
    always_comb begin
        state_nxt  = state;
        inst_busy  = 1'b0;
        inst_valid = 1'b0;
        load_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (inst_req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_WAIT;
                        inst_busy = 1'b1;
                    end
                end else if (load_we) begin
                    load_ready = 1'b1;
                end
            end
            ST_WAIT: begin
                inst_busy = 1'b1;
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                inst_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture, wait counter and response registers (held between responses)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt        <= 4'd0;
            req_idx         <= '0;
            req_mis         <= 1'b0;
            inst_data       <= '0;
            inst_misaligned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inst_req) begin
                        req_idx  <= addr_idx;
                        req_mis  <= addr_mis;
                        wait_cnt <= WAIT_LOAD;
                        // Zero wait states: the array is read on the request edge itself.
                        if (WAIT_CYCLES == 0) begin
                            inst_data       <= mem[addr_idx];
                            inst_misaligned <= addr_mis;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        inst_data       <= mem[req_idx];
                        inst_misaligned <= req_mis;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Loader write port; only accepted while idle with no competing fetch
    always_ff @(posedge clk) begin
        if (load_ready) begin
            mem[load_idx] <= load_wdata;
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed, self-checking bench for inst_mem_responder with 0, 3 and 2 wait states.
module tb_inst_mem_responder;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    // WAIT_CYCLES = 0 instance
    logic        d0_req, d0_we, d0_valid, d0_busy, d0_mis, d0_ready;
    logic [11:0] d0_addr, d0_laddr;
    logic [31:0] d0_data, d0_wdata;
    // WAIT_CYCLES = 3 instance
    logic        d3_req, d3_we, d3_valid, d3_busy, d3_mis, d3_ready;
    logic [11:0] d3_addr, d3_laddr;
    logic [31:0] d3_data, d3_wdata;
    // WAIT_CYCLES = 2 instance
    logic        d2_req, d2_we, d2_valid, d2_busy, d2_mis, d2_ready;
    logic [11:0] d2_addr, d2_laddr;
    logic [31:0] d2_data, d2_wdata;

    inst_mem_responder #(.XLEN(32), .AWIDTH(12), .WAIT_CYCLES(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .inst_req(d0_req), .inst_addr(d0_addr),
        .inst_data(d0_data), .inst_valid(d0_valid), .inst_busy(d0_busy),
        .inst_misaligned(d0_mis), .load_we(d0_we), .load_addr(d0_laddr),
        .load_wdata(d0_wdata), .load_ready(d0_ready)
    );

    inst_mem_responder #(.XLEN(32), .AWIDTH(12), .WAIT_CYCLES(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .inst_req(d3_req), .inst_addr(d3_addr),
        .inst_data(d3_data), .inst_valid(d3_valid), .inst_busy(d3_busy),
        .inst_misaligned(d3_mis), .load_we(d3_we), .load_addr(d3_laddr),
        .load_wdata(d3_wdata), .load_ready(d3_ready)
    );

    inst_mem_responder #(.XLEN(32), .AWIDTH(12), .WAIT_CYCLES(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .inst_req(d2_req), .inst_addr(d2_addr),
        .inst_data(d2_data), .inst_valid(d2_valid), .inst_busy(d2_busy),
        .inst_misaligned(d2_mis), .load_we(d2_we), .load_addr(d2_laddr),
        .load_wdata(d2_wdata), .load_ready(d2_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        req;
        logic [11:0] addr;
        logic        we;
        logic [11:0] laddr;
        logic [31:0] wdata;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_busy;
        logic        e_mis;
        logic        e_ready;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        {d0_req, d0_we, d3_req, d3_we, d2_req, d2_we} = '0;
        {d0_addr, d0_laddr, d3_addr, d3_laddr, d2_addr, d2_laddr} = '0;
        {d0_wdata, d3_wdata, d2_wdata} = '0;

        //           req  addr     we   laddr    wdata         val  data          busy mis  rdy
        vecs[0]  = '{1'b0, 12'h000, 1'b0, 12'h000, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 12'h000, 1'b1, 12'h000, 32'h00000013, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 12'h000, 1'b1, 12'h008, 32'h22222222, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 12'h000, 1'b1, 12'h00C, 32'h0C0C0C0C, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 12'h000, 1'b0, 12'h000, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 12'h000, 1'b0, 12'h000, 32'h0,        1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 12'h000, 1'b0, 12'h000, 32'h0,        1'b0, 32'h00000013, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 12'h008, 1'b1, 12'h008, 32'h11111111, 1'b0, 32'h00000013, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 12'h000, 1'b1, 12'h008, 32'h11111111, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 12'h000, 1'b1, 12'h008, 32'h11111111, 1'b0, 32'h22222222, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 12'h008, 1'b0, 12'h000, 32'h0,        1'b0, 32'h22222222, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 12'h000, 1'b0, 12'h000, 32'h0,        1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 12'h00A, 1'b0, 12'h000, 32'h0,        1'b0, 32'h11111111, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 12'h000, 1'b0, 12'h000, 32'h0,        1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 12'h000, 1'b0, 12'h000, 32'h0,        1'b0, 32'h11111111, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 12'h00C, 1'b0, 12'h000, 32'h0,        1'b0, 32'h11111111, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 12'h000, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0C0C0C0C, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 12'h000, 1'b0, 12'h000, 32'h0,        1'b0, 32'h0C0C0C0C, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 12'h008, 1'b0, 12'h000, 32'h0,        1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 12'h000, 1'b0, 12'h000, 32'h0,        1'b0, 32'h00000013, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 12'h000, 1'b0, 12'h000, 32'h0,        1'b0, 32'h00000013, 1'b0, 1'b0, 1'b0};

        repeat (3) step();
        rst_n = 1'b1;

        // Reset state of all instances
        @(negedge clk);
        chk("rst d3 valid", {31'b0, d3_valid}, 32'h0);
        chk("rst d3 data",  d3_data, 32'h0);
        chk("rst d3 busy",  {31'b0, d3_busy}, 32'h0);
        chk("rst d2 valid", {31'b0, d2_valid}, 32'h0);
        chk("rst d2 data",  d2_data, 32'h0);
        step();

        // Table-driven cycle vectors on the zero-wait-state instance
        for (int i = 0; i < 21; i++) begin
            d0_req   = vecs[i].req;
            d0_addr  = vecs[i].addr;
            d0_we    = vecs[i].we;
            d0_laddr = vecs[i].laddr;
            d0_wdata = vecs[i].wdata;
            @(negedge clk);
            chk($sformatf("v%0d valid", i), {31'b0, d0_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d data", i),  d0_data, vecs[i].e_data);
            chk($sformatf("v%0d busy", i),  {31'b0, d0_busy}, {31'b0, vecs[i].e_busy});
            chk($sformatf("v%0d mis", i),   {31'b0, d0_mis}, {31'b0, vecs[i].e_mis});
            chk($sformatf("v%0d ready", i), {31'b0, d0_ready}, {31'b0, vecs[i].e_ready});
            step();
        end
        d0_req = 1'b0;
        d0_we  = 1'b0;

        // WAIT_CYCLES=3: load, then request with busy/latency checks
        d3_we = 1'b1; d3_laddr = 12'h004; d3_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("d3 load ready", {31'b0, d3_ready}, 32'h1);
        step();
        d3_we = 1'b0; d3_req = 1'b1; d3_addr = 12'h004;
        @(negedge clk);
        chk("d3 c0 busy",  {31'b0, d3_busy}, 32'h1);
        chk("d3 c0 valid", {31'b0, d3_valid}, 32'h0);
        step();
        d3_req = 1'b0;
        d3_we = 1'b1; d3_laddr = 12'h010; d3_wdata = 32'h12345678;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("d3 c%0d busy", c),  {31'b0, d3_busy}, 32'h1);
            chk($sformatf("d3 c%0d valid", c), {31'b0, d3_valid}, 32'h0);
            chk($sformatf("d3 c%0d ready", c), {31'b0, d3_ready}, 32'h0);
            step();
        end
        @(negedge clk);
        chk("d3 c4 valid", {31'b0, d3_valid}, 32'h1);
        chk("d3 c4 data",  d3_data, 32'hDEADBEEF);
        chk("d3 c4 busy",  {31'b0, d3_busy}, 32'h0);
        chk("d3 c4 ready", {31'b0, d3_ready}, 32'h0);
        step();
        @(negedge clk);
        chk("d3 c5 ready", {31'b0, d3_ready}, 32'h1);
        chk("d3 c5 valid", {31'b0, d3_valid}, 32'h0);
        chk("d3 c5 data",  d3_data, 32'hDEADBEEF);
        step();
        d3_we = 1'b0;
        @(negedge clk);
        chk("d3 c6 data", d3_data, 32'hDEADBEEF);
        step();

        // WAIT_CYCLES=3: reset asserted in the middle of WAIT
        d3_req = 1'b1; d3_addr = 12'h010;
        step();
        d3_req = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst mid valid", {31'b0, d3_valid}, 32'h0);
        chk("rst mid data",  d3_data, 32'h0);
        chk("rst mid busy",  {31'b0, d3_busy}, 32'h0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst c%0d valid", c), {31'b0, d3_valid}, 32'h0);
            chk($sformatf("post-rst c%0d busy", c),  {31'b0, d3_busy}, 32'h0);
            step();
        end
        d3_req = 1'b1; d3_addr = 12'h010;
        step();
        d3_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("re-req c%0d valid", c), {31'b0, d3_valid}, {31'b0, (c == 4)});
            if (c == 4) chk("re-req data", d3_data, 32'h12345678);
            step();
        end

        // WAIT_CYCLES=2: second request during WAIT must be ignored
        d2_we = 1'b1; d2_laddr = 12'h000; d2_wdata = 32'hAAAA0000;
        @(negedge clk);
        chk("d2 load0 ready", {31'b0, d2_ready}, 32'h1);
        step();
        d2_laddr = 12'h004; d2_wdata = 32'hBBBB0004;
        step();
        d2_we = 1'b0; d2_req = 1'b1; d2_addr = 12'h000;
        @(negedge clk);
        chk("d2 c0 busy", {31'b0, d2_busy}, 32'h1);
        step();
        d2_addr = 12'h004;
        @(negedge clk);
        chk("d2 c1 busy",  {31'b0, d2_busy}, 32'h1);
        chk("d2 c1 valid", {31'b0, d2_valid}, 32'h0);
        step();
        d2_req = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("d2 c%0d valid", c), {31'b0, d2_valid}, {31'b0, (c == 3)});
            if (c == 3) chk("d2 c3 data", d2_data, 32'hAAAA0000);
            step();
        end
        @(negedge clk);
        chk("d2 final data", d2_data, 32'hAAAA0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
